// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request controller: FSM state encoding and
// the request record that travels through the request FIFO.
package mem_ctrl_pkg;

  localparam int MC_ADDR_W = 8;
  localparam int MC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [MC_ADDR_W-1:0] addr;
    logic [MC_DATA_W-1:0] wdata;
  } req_t;

  localparam int MC_REQ_W = $bits(req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// Small synchronous request FIFO; the occupancy count separates full from
// empty so the pointers can wrap freely modulo FIFO_DEPTH.
module mem_req_fifo #(
  parameter int W          = 41,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  store [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = store[rd_ptr];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge Clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request-side controller in front of the word memory: buffers requests,
// issues them one at a time, and flags out-of-range or unwritten reads.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  // Both handshakes: a transfer happens on the rising Clk edge where valid
  // and ready are both high; valid never waits on ready, payload is held
  // stable while valid is high and ready is low.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        dbg_state
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ISSUE   = ISSUE;
  localparam logic [1:0] S_WAIT_RD = WAIT_RD;
  localparam logic [1:0] S_RESP    = RESP;

  logic [1:0]        state;
  logic [DEPTH-1:0]  written;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [REQ_W-1:0]  fifo_head;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              head_in_range;
  logic              head_written;
  logic              head_err;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              issue;

  mem_req_fifo #(
    .W          (REQ_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (req_valid && req_ready),
    .pop   (fifo_pop),
    .din   ({req_we, req_addr, req_wdata}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign req_ready = !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign {head_we, head_addr, head_wdata} = fifo_head;

  assign head_in_range = {1'b0, head_addr} < (ADDR_W + 1)'(DEPTH);

  always_comb begin
    head_written = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head_addr == ADDR_W'(i)) head_written = written[i];
    end
  end

  // Errors are decided at pop time so bad requests never touch the memory.
  assign head_err = !head_in_range || (!head_we && !head_written);

  assign issue     = (state == S_ISSUE);
  assign mem_valid = issue;
  assign mem_rw    = issue && cur_we;
  assign mem_addr  = issue ? cur_addr : '0;
  assign mem_din   = (issue && cur_we) ? cur_wdata : '0;
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      written   <= '0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_we    <= head_we;
            cur_addr  <= head_addr;
            cur_wdata <= head_wdata;
            rsp_we    <= head_we;
            if (head_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (cur_we) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (cur_addr == ADDR_W'(i)) written[i] <= 1'b1;
            end
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            state <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          rsp_rdata <= mem_dout;
          rsp_err   <= 1'b0;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a word-memory model, a response scoreboard fed
// at request acceptance, a vector table and directed multi-cycle sequences.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_din;
  logic [7:0]  mem_addr;
  logic        mem_rw;
  logic        mem_valid;
  logic [31:0] mem_dout = '0;
  logic [1:0]  dbg_state;

  mem_access_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_din   (mem_din),
    .mem_addr  (mem_addr),
    .mem_rw    (mem_rw),
    .mem_valid (mem_valid),
    .mem_dout  (mem_dout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / response-ready driver ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  bit rdy_rand  = 1'b0;
  bit rdy_level = 1'b1;
  always @(posedge Clk) begin
    #1;
    rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  // Word memory with registered read data.
  logic [31:0] mem_arr [256];
  always @(posedge Clk) begin
    if (mem_valid) begin
      if (mem_rw) mem_arr[mem_addr] <= mem_din;
      else        mem_dout <= mem_arr[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int          rsp_cyc_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          mem_cnt = 0;
  int          idle_viol = 0;
  logic [7:0]  last_mem_addr;
  logic [31:0] last_mem_din;
  logic        last_mem_rw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (mem_valid) begin
        mem_cnt++;
        last_mem_addr = mem_addr;
        last_mem_din  = mem_din;
        last_mem_rw   = mem_rw;
      end else if (mem_addr != 0 || mem_din != 0 || mem_rw) begin
        idle_viol++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got %0h, want none", {rsp_we, rsp_err, rsp_rdata});
        end else begin
          check("rsp", {30'd0, rsp_we, rsp_err, rsp_rdata}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- reference model and drivers ----------------
  logic [7:0]  model_wr = '0;
  logic [31:0] model_mem [8];
  int          last_e0 = 0;

  function automatic logic [33:0] model_exp(input logic we, input logic [7:0] addr);
    if (addr >= 8)               return {we, 1'b1, 32'h0};
    if (we)                      return {1'b1, 1'b0, 32'h0};
    if (!model_wr[addr[2:0]])    return {1'b0, 1'b1, 32'h0};
    return {2'b00, model_mem[addr[2:0]]};
  endfunction

  // Call with inputs phase-aligned just after a rising edge.
  task automatic send(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [33:0] exp);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge Clk);
      acc = req_ready;
      if (acc) begin
        exp_q.push_back(exp);
        last_e0 = cyc + 1;
        if (we && addr < 8) begin
          model_wr[addr[2:0]]  = 1'b1;
          model_mem[addr[2:0]] = wdata;
        end
      end
      @(posedge Clk);
      #1;
    end
    req_valid = 1'b0;
    check("send_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_rsp_lat(output int lat);
    lat = -1;
    for (int g = 0; g < 50; g++) begin
      @(negedge Clk);
      if (rsp_valid) begin
        lat = cyc - last_e0 + 1;
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int g = 0; g < 600 && exp_q.size() != 0; g++) @(posedge Clk);
    @(posedge Clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  // ---------------- test sequence ----------------
  initial begin
    int          lat;
    int          m0;
    int          n0;
    int          hold_viol;
    bit          found;
    logic [33:0] snap;
    logic        rwe;
    logic [7:0]  raddr;
    logic [31:0] rdat;

    vecs[0] = '{1'b1, 8'd0,   32'h11111111, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 8'd7,   32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 8'd0,   32'h0,        1'b0, 32'h11111111};
    vecs[3] = '{1'b0, 8'd7,   32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[4] = '{1'b0, 8'd6,   32'h0,        1'b1, 32'h0};
    vecs[5] = '{1'b0, 8'd255, 32'h0,        1'b1, 32'h0};
    vecs[6] = '{1'b1, 8'd9,   32'hCAFEF00D, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 8'd0,   32'h22222222, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 8'd0,   32'h0,        1'b0, 32'h22222222};
    vecs[9] = '{1'b0, 8'd3,   32'h0,        1'b0, 32'hDEADBEEF};

    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_we, rsp_err, rsp_rdata}, 0);
    check("rst_mem_pins", {mem_valid, mem_rw, mem_addr, mem_din}, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_state", dbg_state, 0);
    @(posedge Clk);
    #1;

    // Write then read of addr 3, with latency and memory pin checks.
    send(1'b1, 8'd3, 32'hDEADBEEF, {1'b1, 1'b0, 32'h0});
    wait_rsp_lat(lat);
    check("wr_latency", lat, 3);
    check("wr_mem_pins", {last_mem_rw, last_mem_addr, last_mem_din}, {1'b1, 8'd3, 32'hDEADBEEF});
    send(1'b0, 8'd3, 32'h0, {2'b00, 32'hDEADBEEF});
    wait_rsp_lat(lat);
    check("rd_latency", lat, 4);
    check("rd_mem_pins", {last_mem_rw, last_mem_addr, last_mem_din}, {1'b0, 8'd3, 32'h0});
    wait_drain();

    // Unwritten read and out-of-range accesses never reach the memory.
    m0 = mem_cnt;
    send(1'b0, 8'd5, 32'h0, {1'b0, 1'b1, 32'h0});
    wait_rsp_lat(lat);
    check("err_latency", lat, 2);
    send(1'b1, 8'd8, 32'h12345678, {1'b1, 1'b1, 32'h0});
    send(1'b0, 8'd8, 32'h0, {1'b0, 1'b1, 32'h0});
    wait_drain();
    check("err_no_mem_access", mem_cnt - m0, 0);

    // Vector table, back to back.
    foreach (vecs[i]) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata,
           {vecs[i].we, vecs[i].exp_err, vecs[i].exp_rdata});
    end
    wait_drain();

    // Issue cadence: writes every 3 cycles, reads every 4.
    n0 = rsp_cyc_q.size();
    send(1'b1, 8'd1, 32'h01010101, {1'b1, 1'b0, 32'h0});
    send(1'b1, 8'd2, 32'h02020202, {1'b1, 1'b0, 32'h0});
    wait_drain();
    check("wr_period", rsp_cyc_q[n0 + 1] - rsp_cyc_q[n0], 3);
    n0 = rsp_cyc_q.size();
    send(1'b0, 8'd1, 32'h0, {2'b00, 32'h01010101});
    send(1'b0, 8'd2, 32'h0, {2'b00, 32'h02020202});
    wait_drain();
    check("rd_period", rsp_cyc_q[n0 + 1] - rsp_cyc_q[n0], 4);

    // Backpressure: consumer stalls, FIFO fills, a fourth request waits.
    rdy_level = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    send(1'b1, 8'd4, 32'h44444444, {1'b1, 1'b0, 32'h0});
    send(1'b0, 8'd4, 32'h0,        {2'b00, 32'h44444444});
    send(1'b1, 8'd5, 32'h55555555, {1'b1, 1'b0, 32'h0});
    @(negedge Clk);
    check("full_req_ready", req_ready, 0);
    check("full_rsp_valid", rsp_valid, 1);
    snap = {rsp_we, rsp_err, rsp_rdata};
    check("full_rsp_head", snap, {1'b1, 1'b0, 32'h0});
    hold_viol = 0;
    fork
      send(1'b0, 8'd5, 32'h0, {2'b00, 32'h55555555});
      begin
        repeat (10) begin
          @(negedge Clk);
          if (!rsp_valid || req_ready || {rsp_we, rsp_err, rsp_rdata} != snap) hold_viol++;
        end
        check("hold_stable", hold_viol, 0);
        check("hold_no_accept", exp_q.size(), 3);
        rdy_level = 1'b1;
      end
    join
    wait_drain();

    // Random traffic with a throttled consumer.
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = 8'($urandom_range(0, 9));
      rdat  = $urandom;
      send(rwe, raddr, rdat, model_exp(rwe, raddr));
    end
    rdy_rand = 1'b0;
    wait_drain();

    // Reset while a read of a written word sits in WAIT_RD.
    send(1'b1, 8'd2, 32'h2222AAAA, {1'b1, 1'b0, 32'h0});
    wait_drain();
    send(1'b0, 8'd2, 32'h0, {2'b00, 32'h2222AAAA});
    found = 1'b0;
    for (int g = 0; g < 20 && !found; g++) begin
      @(negedge Clk);
      found = (dbg_state == 2'd2);
    end
    check("reach_wait_rd", {63'd0, found}, 64'd1);
    Reset = 1'b1;
    exp_q.delete();
    model_wr = '0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_fields", {rsp_we, rsp_err, rsp_rdata, mem_valid}, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check("post_rst_idle", {rsp_valid, dbg_state, req_ready}, {1'b0, 2'd0, 1'b1});
    send(1'b0, 8'd2, 32'h0, {1'b0, 1'b1, 32'h0});
    wait_drain();

    check("final_queue_empty", exp_q.size(), 0);
    check("mem_pins_idle_zero", idle_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Request-side controller sitting directly upstream of the word memory. Accepts CPU-style read/write requests over a valid/ready handshake, buffers them in a small FIFO, drives the memory's Din/Addr/R_W/Valid pins, captures registered read data one cycle later, and returns one response per request over a second valid/ready handshake. Tracks which words have been written since reset so that reads of uninitialised (X) words and out-of-range addresses are reported as errors instead of propagating X.

## Interface
- ADDR_W, 8, address width; must match the memory's address width
- DATA_W, 32, data width; must match the memory's data width
- DEPTH, 8, number of memory words; legal addresses are 0..DEPTH-1
- FIFO_DEPTH, 2, request FIFO entries, power of two, >=2
- Clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-high; shared with the memory
- req_valid  input  1  request present
- req_ready  output  1  FIFO not full
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_we  output  1  echoes req_we of the answered request
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors
- rsp_err  output  1  out-of-range address, or read of unwritten word
- mem_din  output  DATA_W  to memory Din
- mem_addr  output  ADDR_W  to memory Addr
- mem_rw  output  1  to memory R_W (1 = write)
- mem_valid  output  1  to memory Valid
- mem_dout  input  DATA_W  from memory Dout (registered, 1-cycle)

## Operation
- Push on req_valid && req_ready; req_ready = !fifo_full (combinational from FIFO count, not from req_valid).
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: if FIFO non-empty, pop head and classify:
  - addr >= DEPTH -> RESP, rsp_err=1, rsp_rdata=0, no memory access.
  - read of addr with written[addr]=0 -> RESP, rsp_err=1, rsp_rdata=0, no memory access.
  - otherwise -> ISSUE.
- ISSUE: mem_valid=1, mem_rw=req_we, mem_addr, mem_din=wdata (zero for reads). Write: set written[addr], -> RESP (err=0, rdata=0). Read: -> WAIT_RD.
- WAIT_RD: register mem_dout into rsp_rdata, -> RESP.
- RESP: rsp_valid=1; hold rsp_* stable until rsp_ready; on handshake -> IDLE.
- mem_valid is 0 in every state except ISSUE; mem_addr/mem_din/mem_rw are 0 outside ISSUE.
- One request in flight; strictly in-order.
- written[] is DEPTH bits; only ISSUE writes set bits; only Reset clears.

## Timing
- Reset (async): state IDLE, FIFO empty, written=0, rsp_valid=0, rsp_we=0, rsp_err=0, rsp_rdata=0, mem_valid=0, mem_rw=0, mem_addr=0, mem_din=0; req_ready=1 after reset.
- Push at edge E0 into empty FIFO, idle FSM: IDLE sees entry in cycle after E0; ISSUE next cycle; write rsp_valid 3 cycles after E0, read 4 cycles, error 2 cycles.
- rsp_ready high on first rsp_valid cycle: FSM back in IDLE next cycle; back-to-back writes issue every 3 cycles, reads every 4.
- Push and pop in the same cycle permitted when not full; count unchanged.
- FIFO full: req_ready=0; requests held by producer, no drop.
- Reset mid-operation (any state): in-flight and buffered requests discarded, no response produced.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH; count distinguishes full/empty.

## Structure
- Package mem_ctrl_pkg: state enum (IDLE, ISSUE, WAIT_RD, RESP), packed request struct {we, addr, wdata} parameterised via localparams matching defaults.
- Sub-module mem_req_fifo: synchronous FIFO with async active-high reset, push/pop/full/empty/head outputs.
- Top instantiates mem_req_fifo plus FSM and written[] register.

## Test plan
- Write 0xDEADBEEF to addr 3, then read addr 3 -> write rsp (rsp_we=1, err=0) at E0+3; read rsp rdata=0xDEADBEEF, err=0 at +4 after its push.
- Read addr 5 after reset with no prior write -> rsp_err=1, rdata=0, mem_valid never asserted.
- Write to addr 8 (DEPTH=8) -> rsp_err=1, mem_valid never asserted; following read of 8 also err=1.
- Hold rsp_ready=0 for 10 cycles with 3 requests offered -> FIFO fills, req_ready=0, rsp_* stable; release -> all 3 responses in order, none lost.
- Assert Reset during WAIT_RD of a read to written addr 2 -> no response, rsp_valid=0, written cleared; subsequent read of addr 2 -> rsp_err=1.
